// File: rtl/cory_rr_merge8.sv
// Eight-input round-robin merge with optional per-source burst hold; output beat is registered, one cycle after grant.
// Backpressure: input readies fall to zero whenever a held output beat is not being accepted downstream.
module cory_rr_merge8 #(
    parameter int N     = 8,
    parameter int BURST = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_a0_v,
    input  logic         i_a1_v,
    input  logic         i_a2_v,
    input  logic         i_a3_v,
    input  logic         i_a4_v,
    input  logic         i_a5_v,
    input  logic         i_a6_v,
    input  logic         i_a7_v,
    input  logic [N-1:0] i_a0_d,
    input  logic [N-1:0] i_a1_d,
    input  logic [N-1:0] i_a2_d,
    input  logic [N-1:0] i_a3_d,
    input  logic [N-1:0] i_a4_d,
    input  logic [N-1:0] i_a5_d,
    input  logic [N-1:0] i_a6_d,
    input  logic [N-1:0] i_a7_d,
    output logic         o_a0_r,
    output logic         o_a1_r,
    output logic         o_a2_r,
    output logic         o_a3_r,
    output logic         o_a4_r,
    output logic         o_a5_r,
    output logic         o_a6_r,
    output logic         o_a7_r,
    output logic         o_z_v,
    output logic [N-1:0] o_z_d,
    output logic [2:0]   o_z_s,
    input  logic         i_z_r
);

    logic [7:0]   w_v;
    logic [N-1:0] w_d [8];
    logic [7:0]   w_rdy;
    logic         w_ld;
    logic         w_hold;
    logic         w_gnt;
    logic [2:0]   w_g;
    logic [3:0]   w_pick;
    logic [4:0]   w_c;

    logic         r_z_v;
    logic [N-1:0] r_z_d;
    logic [2:0]   r_z_s;
    logic [2:0]   r_last;
    logic [3:0]   r_cnt;

    // Returns {found, index} of the first set bit of v scanning upward from 'from', wrapping mod 8.
    function automatic logic [3:0] f_pick(input logic [7:0] v, input logic [2:0] from);
        logic [2:0] idx;
        f_pick = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = from + 3'(k);
            if (v[idx]) f_pick = {1'b1, idx};
        end
    endfunction

    assign w_v = {i_a7_v, i_a6_v, i_a5_v, i_a4_v, i_a3_v, i_a2_v, i_a1_v, i_a0_v};

    assign w_d[0] = i_a0_d;
    assign w_d[1] = i_a1_d;
    assign w_d[2] = i_a2_d;
    assign w_d[3] = i_a3_d;
    assign w_d[4] = i_a4_d;
    assign w_d[5] = i_a5_d;
    assign w_d[6] = i_a6_d;
    assign w_d[7] = i_a7_d;

    assign w_ld   = !r_z_v || i_z_r;
    assign w_hold = (r_cnt != 4'd0) && w_v[r_last];
    assign w_pick = f_pick(w_v, r_last + 3'd1);

    // A holding source keeps the grant; otherwise the previous winner is searched last.
    always_comb begin
        w_gnt = 1'b0;
        w_g   = 3'd0;
        if (w_hold) begin
            w_gnt = 1'b1;
            w_g   = r_last;
        end else begin
            w_gnt = w_pick[3];
            w_g   = w_pick[2:0];
        end
    end

    assign w_c   = w_hold ? ({1'b0, r_cnt} + 5'd1) : 5'd1;
    assign w_rdy = (w_gnt && w_ld && !reset) ? (8'd1 << w_g) : 8'd0;

    assign o_a0_r = w_rdy[0];
    assign o_a1_r = w_rdy[1];
    assign o_a2_r = w_rdy[2];
    assign o_a3_r = w_rdy[3];
    assign o_a4_r = w_rdy[4];
    assign o_a5_r = w_rdy[5];
    assign o_a6_r = w_rdy[6];
    assign o_a7_r = w_rdy[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_z_v  <= 1'b0;
            r_z_d  <= '0;
            r_z_s  <= 3'd0;
            r_last <= 3'd7;
            r_cnt  <= 4'd0;
        end else if (w_ld) begin
            if (w_gnt) begin
                r_z_v  <= 1'b1;
                r_z_d  <= w_d[w_g];
                r_z_s  <= w_g;
                r_last <= w_g;
                r_cnt  <= (w_c == 5'(BURST)) ? 4'd0 : w_c[3:0];
            end else begin
                r_z_v  <= 1'b0;
            end
        end
    end

    assign o_z_v = r_z_v;
    assign o_z_d = r_z_d;
    assign o_z_s = r_z_s;

endmodule
